// File: rtl/axil_reg_responder.sv
// AXI4-Lite responder with NUM_REGS 32-bit registers; independent write and read FSMs.
// Define AXIL_RESP_SLVERR_EN to answer out-of-range accesses with SLVERR instead of OKAY.
module axil_reg_responder #(
    parameter int ADDR_WIDTH = 6,
    parameter int NUM_REGS   = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  S_AXI_ACLK,
    input  logic                  S_AXI_ARESET,
    input  logic [ADDR_WIDTH-1:0] S_AXI_AWADDR,
    input  logic [2:0]            S_AXI_AWPROT,
    input  logic                  S_AXI_AWVALID,
    output logic                  S_AXI_AWREADY,
    input  logic [31:0]           S_AXI_WDATA,
    input  logic [3:0]            S_AXI_WSTRB,
    input  logic                  S_AXI_WVALID,
    output logic                  S_AXI_WREADY,
    output logic [1:0]            S_AXI_BRESP,
    output logic                  S_AXI_BVALID,
    input  logic                  S_AXI_BREADY,
    input  logic [ADDR_WIDTH-1:0] S_AXI_ARADDR,
    input  logic [2:0]            S_AXI_ARPROT,
    input  logic                  S_AXI_ARVALID,
    output logic                  S_AXI_ARREADY,
    output logic [31:0]           S_AXI_RDATA,
    output logic [1:0]            S_AXI_RRESP,
    output logic                  S_AXI_RVALID,
    input  logic                  S_AXI_RREADY,
    output logic [CNT_WIDTH-1:0]  WR_CNT,
    output logic [CNT_WIDTH-1:0]  RD_CNT
);
    localparam int IDX_W = ADDR_WIDTH - 2;
    localparam logic [IDX_W:0] REG_LIMIT = (IDX_W + 1)'(NUM_REGS);
    localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef AXIL_RESP_SLVERR_EN
    localparam logic [1:0] RESP_OOR = 2'b10;
`else
    localparam logic [1:0] RESP_OOR = 2'b00;
`endif

    typedef enum logic {WR_IDLE, WR_RESP} wr_state_e;
    typedef enum logic {RD_IDLE, RD_RESP} rd_state_e;

    wr_state_e            wr_state_q, wr_state_d;
    logic                 awready_q, awready_d, wready_q, wready_d;
    logic                 aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic [IDX_W-1:0]     aw_idx_q, aw_idx_d;
    logic [31:0]          wdata_q, wdata_d;
    logic [3:0]           wstrb_q, wstrb_d;
    logic                 bvalid_q, bvalid_d;
    logic [1:0]           bresp_q, bresp_d;
    logic [CNT_WIDTH-1:0] wr_cnt_q, wr_cnt_d;
    logic [31:0]          regs_q [NUM_REGS];
    logic [31:0]          regs_d [NUM_REGS];

    rd_state_e            rd_state_q, rd_state_d;
    logic                 arready_q, arready_d;
    logic                 rvalid_q, rvalid_d;
    logic [31:0]          rdata_q, rdata_d;
    logic [1:0]           rresp_q, rresp_d;
    logic [CNT_WIDTH-1:0] rd_cnt_q, rd_cnt_d;

    logic             aw_hs, w_hs, ar_hs;
    logic [IDX_W-1:0] wr_idx, rd_idx;
    logic [31:0]      wr_data, rd_value;
    logic [3:0]       wr_strb;
    logic             wr_in_range, rd_in_range;
    logic             unused_inputs;

    assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    // A channel may complete in the commit cycle itself, so take the live bus value then.
    assign aw_hs       = S_AXI_AWVALID && awready_q;
    assign w_hs        = S_AXI_WVALID && wready_q;
    assign ar_hs       = S_AXI_ARVALID && arready_q;
    assign wr_idx      = aw_hs ? S_AXI_AWADDR[ADDR_WIDTH-1:2] : aw_idx_q;
    assign wr_data     = w_hs ? S_AXI_WDATA : wdata_q;
    assign wr_strb     = w_hs ? S_AXI_WSTRB : wstrb_q;
    assign rd_idx      = S_AXI_ARADDR[ADDR_WIDTH-1:2];
    assign wr_in_range = {1'b0, wr_idx} < REG_LIMIT;
    assign rd_in_range = {1'b0, rd_idx} < REG_LIMIT;

    always_comb begin
        rd_value = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_idx == IDX_W'(i)) rd_value = regs_q[i];
        end
    end

    // NOTE: every *_d gets its hold value first, so no path through this block infers a latch.
    always_comb begin
        wr_state_d = wr_state_q;
        awready_d  = awready_q;
        wready_d   = wready_q;
        aw_done_d  = aw_done_q;
        w_done_d   = w_done_q;
        aw_idx_d   = aw_idx_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        wr_cnt_d   = wr_cnt_q;
        regs_d     = regs_q;
        case (wr_state_q)
            WR_IDLE: begin
                if (aw_hs) begin
                    aw_idx_d  = S_AXI_AWADDR[ADDR_WIDTH-1:2];
                    aw_done_d = 1'b1;
                end
                if (w_hs) begin
                    wdata_d  = S_AXI_WDATA;
                    wstrb_d  = S_AXI_WSTRB;
                    w_done_d = 1'b1;
                end
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                    for (int i = 0; i < NUM_REGS; i++) begin
                        if (wr_idx == IDX_W'(i)) begin
                            for (int b = 0; b < 4; b++) begin
                                if (wr_strb[b]) regs_d[i][8*b +: 8] = wr_data[8*b +: 8];
                            end
                        end
                    end
                    bvalid_d   = 1'b1;
                    bresp_d    = wr_in_range ? RESP_OKAY : RESP_OOR;
                    aw_done_d  = 1'b0;
                    w_done_d   = 1'b0;
                    awready_d  = 1'b0;
                    wready_d   = 1'b0;
                    wr_state_d = WR_RESP;
                end else begin
                    awready_d = !(aw_done_q || aw_hs);
                    wready_d  = !(w_done_q || w_hs);
                end
            end
            WR_RESP: begin
                if (S_AXI_BREADY) begin
                    bvalid_d   = 1'b0;
                    wr_cnt_d   = wr_cnt_q + CNT_WIDTH'(1);
                    awready_d  = 1'b1;
                    wready_d   = 1'b1;
                    wr_state_d = WR_IDLE;
                end
            end
        endcase
    end

    always_comb begin
        rd_state_d = rd_state_q;
        arready_d  = arready_q;
        rvalid_d   = rvalid_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        rd_cnt_d   = rd_cnt_q;
        case (rd_state_q)
            RD_IDLE: begin
                arready_d = 1'b1;
                if (ar_hs) begin
                    rdata_d    = rd_in_range ? rd_value : 32'h0;
                    rresp_d    = rd_in_range ? RESP_OKAY : RESP_OOR;
                    rvalid_d   = 1'b1;
                    arready_d  = 1'b0;
                    rd_state_d = RD_RESP;
                end
            end
            RD_RESP: begin
                if (S_AXI_RREADY) begin
                    rvalid_d   = 1'b0;
                    rd_cnt_d   = rd_cnt_q + CNT_WIDTH'(1);
                    arready_d  = 1'b1;
                    rd_state_d = RD_IDLE;
                end
            end
        endcase
    end

    // NOTE: the register file is architecturally reset, so it is built from flops, not a RAM.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            wr_state_q <= WR_IDLE;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            aw_idx_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            wr_cnt_q   <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
            rd_state_q <= RD_IDLE;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
            rd_cnt_q   <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
            aw_idx_q   <= aw_idx_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            wr_cnt_q   <= wr_cnt_d;
            regs_q     <= regs_d;
            rd_state_q <= rd_state_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            rd_cnt_q   <= rd_cnt_d;
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;
    assign WR_CNT        = wr_cnt_q;
    assign RD_CNT        = rd_cnt_q;
endmodule

// File: tb/tb_axil_reg_responder.sv
// Bench for axil_reg_responder: directed scenarios plus random traffic against an array model.
// CNT_WIDTH is reduced so the completion counters wrap within the run.
module tb_axil_reg_responder;
    localparam int ADDR_WIDTH = 6;
    localparam int NUM_REGS   = 4;
    localparam int CNT_WIDTH  = 4;
`ifdef AXIL_RESP_SLVERR_EN
    localparam logic [1:0] OOR_RESP = 2'b10;
`else
    localparam logic [1:0] OOR_RESP = 2'b00;
`endif

    logic clk = 1'b0;
    logic rst;
    logic [ADDR_WIDTH-1:0] awaddr, araddr;
    logic [2:0]            awprot, arprot;
    logic                  awvalid, awready, wvalid, wready, bvalid, bready;
    logic                  arvalid, arready, rvalid, rready;
    logic [31:0]           wdata, rdata;
    logic [3:0]            wstrb;
    logic [1:0]            bresp, rresp;
    logic [CNT_WIDTH-1:0]  wr_cnt, rd_cnt;

    always #5 clk = ~clk;

    axil_reg_responder #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .NUM_REGS  (NUM_REGS),
        .CNT_WIDTH (CNT_WIDTH)
    ) dut (
        .S_AXI_ACLK   (clk),
        .S_AXI_ARESET (rst),
        .S_AXI_AWADDR (awaddr),
        .S_AXI_AWPROT (awprot),
        .S_AXI_AWVALID(awvalid),
        .S_AXI_AWREADY(awready),
        .S_AXI_WDATA  (wdata),
        .S_AXI_WSTRB  (wstrb),
        .S_AXI_WVALID (wvalid),
        .S_AXI_WREADY (wready),
        .S_AXI_BRESP  (bresp),
        .S_AXI_BVALID (bvalid),
        .S_AXI_BREADY (bready),
        .S_AXI_ARADDR (araddr),
        .S_AXI_ARPROT (arprot),
        .S_AXI_ARVALID(arvalid),
        .S_AXI_ARREADY(arready),
        .S_AXI_RDATA  (rdata),
        .S_AXI_RRESP  (rresp),
        .S_AXI_RVALID (rvalid),
        .S_AXI_RREADY (rready),
        .WR_CNT       (wr_cnt),
        .RD_CNT       (rd_cnt)
    );

    int          tests = 0;
    int          fails = 0;
    logic [31:0] model [NUM_REGS];
    int          exp_wr = 0;
    int          exp_rd = 0;
    logic [31:0] old_val;
    logic [1:0]  coll_resp;
    int          ar_cnt, r_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int cnt_mod(input int n);
        return n % (1 << CNT_WIDTH);
    endfunction

    function automatic logic [1:0] model_write(input logic [ADDR_WIDTH-1:0] addr,
                                               input logic [31:0] data, input logic [3:0] strb);
        int idx = int'(addr) / 4;
        if (idx >= NUM_REGS) return OOR_RESP;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) model[idx][8*b +: 8] = data[8*b +: 8];
        end
        return 2'b00;
    endfunction

    function automatic logic [31:0] model_rdata(input logic [ADDR_WIDTH-1:0] addr);
        int idx = int'(addr) / 4;
        return (idx >= NUM_REGS) ? 32'h0 : model[idx];
    endfunction

    function automatic logic [1:0] model_rresp(input logic [ADDR_WIDTH-1:0] addr);
        return (int'(addr) / 4 >= NUM_REGS) ? OOR_RESP : 2'b00;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NUM_REGS; i++) model[i] = 32'h0;
        exp_wr = 0;
        exp_rd = 0;
    endfunction

    // lead > 0: AW leads W by lead cycles; lead < 0: W leads AW. Called and returns at a negedge.
    task automatic axi_write(input logic [ADDR_WIDTH-1:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int lead, input int hold);
        logic [1:0] exp_resp;
        logic aw_sent, w_sent, aw_fire, w_fire;
        int n;
        exp_resp = model_write(addr, data, strb);
        aw_sent = 1'b0;
        w_sent  = 1'b0;
        n = 0;
        while (!(aw_sent && w_sent) && n < 40) begin
            if (!aw_sent && !awvalid && n >= (lead < 0 ? -lead : 0)) begin
                awaddr  = addr;
                awvalid = 1'b1;
            end
            if (!w_sent && !wvalid && n >= (lead > 0 ? lead : 0)) begin
                wdata  = data;
                wstrb  = strb;
                wvalid = 1'b1;
            end
            aw_fire = awvalid && awready;
            w_fire  = wvalid && wready;
            @(negedge clk);
            n++;
            if (aw_fire) begin awvalid = 1'b0; aw_sent = 1'b1; end
            if (w_fire)  begin wvalid  = 1'b0; w_sent  = 1'b1; end
            if (aw_fire && !w_sent) check("awready_drop", 32'(awready), 32'h0);
            if (w_fire && !aw_sent) check("wready_drop", 32'(wready), 32'h0);
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        check("wr_handshakes", 32'(aw_sent && w_sent), 32'h1);
        check("bvalid_latency", 32'(bvalid), 32'h1);
        check("bresp", 32'(bresp), 32'(exp_resp));
        check("ready_low_in_resp", 32'({awready, wready}), 32'h0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("b_hold_valid", 32'(bvalid), 32'h1);
            check("b_hold_resp", 32'(bresp), 32'(exp_resp));
            check("b_hold_no_aw", 32'(awready), 32'h0);
        end
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        exp_wr++;
        check("bvalid_clear", 32'(bvalid), 32'h0);
        check("awready_back", 32'(awready), 32'h1);
        check("wr_cnt", 32'(wr_cnt), 32'(cnt_mod(exp_wr)));
    endtask

    task automatic axi_read(input logic [ADDR_WIDTH-1:0] addr, input logic [31:0] exp_data,
                            input logic [1:0] exp_resp, input int hold);
        logic fired;
        int n;
        araddr  = addr;
        arvalid = 1'b1;
        fired   = 1'b0;
        n = 0;
        while (!fired && n < 40) begin
            fired = arready;
            @(negedge clk);
            n++;
        end
        arvalid = 1'b0;
        check("ar_handshake", 32'(fired), 32'h1);
        check("rvalid_latency", 32'(rvalid), 32'h1);
        check("rdata", rdata, exp_data);
        check("rresp", 32'(rresp), 32'(exp_resp));
        check("arready_low_in_resp", 32'(arready), 32'h0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("r_hold_valid", 32'(rvalid), 32'h1);
            check("r_hold_data", rdata, exp_data);
            check("r_hold_no_ar", 32'(arready), 32'h0);
        end
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
        exp_rd++;
        check("rvalid_clear", 32'(rvalid), 32'h0);
        check("rd_cnt", 32'(rd_cnt), 32'(cnt_mod(exp_rd)));
    endtask

    initial begin
        rst = 1'b1;
        awaddr = '0; awprot = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_readys", 32'({awready, wready, arready}), 32'h0);
        check("rst_valids", 32'({bvalid, rvalid}), 32'h0);
        check("rst_resps", 32'({bresp, rresp}), 32'h0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_counters", 32'({wr_cnt, rd_cnt}), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("readys_after_reset", 32'({awready, wready, arready}), 32'h7);

        // Self-test pattern
        for (int i = 0; i < 4; i++) axi_write(ADDR_WIDTH'(i * 4), 32'(i + 1), 4'hF, 0, 0);
        for (int i = 0; i < 4; i++) axi_read(ADDR_WIDTH'(i * 4), 32'(i + 1), 2'b00, 0);
        check("selftest_wr_cnt", 32'(wr_cnt), 32'h4);
        check("selftest_rd_cnt", 32'(rd_cnt), 32'h4);

        // Byte strobes
        axi_write(6'h04, 32'hAABBCCDD, 4'hF, 0, 0);
        axi_write(6'h04, 32'h11223344, 4'b0101, 0, 0);
        axi_read(6'h04, 32'hAA22CC44, 2'b00, 0);

        // AW three cycles ahead of W, then W ahead of AW
        axi_write(6'h08, 32'h5A5A5A5A, 4'hF, 3, 0);
        axi_read(6'h08, 32'h5A5A5A5A, 2'b00, 0);
        axi_write(6'h00, 32'h600DF00D, 4'hF, -2, 0);
        axi_read(6'h00, 32'h600DF00D, 2'b00, 0);

        // WSTRB=0 writes nothing
        axi_write(6'h00, 32'hFFFFFFFF, 4'h0, 0, 0);
        axi_read(6'h00, 32'h600DF00D, 2'b00, 0);

        // Backpressure: BREADY/RREADY low for 5 cycles
        axi_write(6'h0C, 32'hCAFEF00D, 4'hF, 0, 5);
        axi_read(6'h0C, 32'hCAFEF00D, 2'b00, 5);

        // Out-of-range write and read
        axi_write(6'h10, 32'h00000BAD, 4'hF, 0, 0);
        for (int i = 0; i < NUM_REGS; i++)
            axi_read(ADDR_WIDTH'(i * 4), model_rdata(ADDR_WIDTH'(i * 4)), 2'b00, 0);
        axi_read(6'h10, 32'h0, OOR_RESP, 0);

        // Read collides with a write commit to the same register
        old_val   = model_rdata(6'h08);
        coll_resp = model_write(6'h08, 32'hC0111DE0, 4'hF);
        awaddr = 6'h08; awvalid = 1'b1;
        wdata = 32'hC0111DE0; wstrb = 4'hF; wvalid = 1'b1;
        araddr = 6'h08; arvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        check("coll_bvalid", 32'(bvalid), 32'h1);
        check("coll_bresp", 32'(bresp), 32'(coll_resp));
        check("coll_rvalid", 32'(rvalid), 32'h1);
        check("coll_old_value", rdata, old_val);
        bready = 1'b1; rready = 1'b1;
        @(negedge clk);
        bready = 1'b0; rready = 1'b0;
        exp_wr++; exp_rd++;
        axi_read(6'h08, 32'hC0111DE0, 2'b00, 0);

        // Back-to-back reads with RREADY held high
        ar_cnt = 0; r_cnt = 0;
        araddr = 6'h00; arvalid = 1'b1; rready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (arvalid && arready) ar_cnt++;
            if (rvalid && rready) begin
                r_cnt++;
                check("b2b_rdata", rdata, model_rdata(6'h00));
            end
            @(negedge clk);
        end
        arvalid = 1'b0; rready = 1'b0;
        exp_rd += 5;
        check("b2b_ar_count", 32'(ar_cnt), 32'h5);
        check("b2b_r_count", 32'(r_cnt), 32'h5);
        check("b2b_rd_cnt", 32'(rd_cnt), 32'(cnt_mod(exp_rd)));

        // Random traffic against the model
        for (int k = 0; k < 40; k++) begin
            logic [ADDR_WIDTH-1:0] a;
            a = ADDR_WIDTH'($urandom_range(0, 23));
            awprot = 3'($urandom);
            arprot = 3'($urandom);
            if ($urandom_range(0, 1) == 1)
                axi_write(a, $urandom, 4'($urandom), int'($urandom_range(0, 6)) - 3,
                          int'($urandom_range(0, 2)));
            else
                axi_read(a, model_rdata(a), model_rresp(a), int'($urandom_range(0, 2)));
        end

        // Reset in the cycle after an AW handshake drops the write
        awaddr = 6'h04; awvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0;
        check("aw_latched", 32'(awready), 32'h0);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_bvalid", 32'(bvalid), 32'h0);
        check("mid_rst_readys", 32'({awready, wready, arready}), 32'h0);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        check("readys_after_mid_rst", 32'({awready, wready, arready}), 32'h7);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("no_b_after_rst", 32'(bvalid), 32'h0);
        end
        check("counters_after_rst", 32'({wr_cnt, rd_cnt}), 32'h0);
        for (int i = 0; i < NUM_REGS; i++) axi_read(ADDR_WIDTH'(i * 4), 32'h0, 2'b00, 0);
        axi_write(6'h04, 32'h12345678, 4'hF, 0, 0);
        axi_read(6'h04, 32'h12345678, 2'b00, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
endmodule
